// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller:
// FSM states, forwarding selects and pipeline-register indices.
package pipeline_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        MEM_WAIT = 2'd2
    } hazard_state_t;

    typedef enum logic [1:0] {
        FWD_REG = 2'd0,
        FWD_MEM = 2'd1,
        FWD_WB  = 2'd2
    } fwd_sel_t;

    localparam int STG_PC    = 0;
    localparam int STG_IFID  = 1;
    localparam int STG_IDEX  = 2;
    localparam int STG_EXMEM = 3;
    localparam int STG_MEMWB = 4;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard controller bundle: decode/EX/MEM/WB register info in, per-boundary
// enables, flushes and forwarding selects out. master = core, slave = controller.
interface pipeline_hazard_ctrl_if #(
    parameter int NUM_STAGES = 5,
    parameter int REG_ADDR_W = 5
);
    logic [REG_ADDR_W-1:0] id_rs1;
    logic [REG_ADDR_W-1:0] id_rs2;
    logic                  id_uses_rs1;
    logic                  id_uses_rs2;
    logic [REG_ADDR_W-1:0] ex_rd;
    logic [REG_ADDR_W-1:0] mem_rd;
    logic [REG_ADDR_W-1:0] wb_rd;
    logic                  ex_reg_write;
    logic                  mem_reg_write;
    logic                  wb_reg_write;
    logic                  ex_mem_read;
    logic                  branch_taken;
    logic                  mem_busy;
    logic [NUM_STAGES-1:0] stage_en;
    logic [NUM_STAGES-1:0] stage_flush;
    logic [1:0]            fwd_sel_1;
    logic [1:0]            fwd_sel_2;
    logic                  lu_stall;

    modport master (
        output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
        output ex_rd, mem_rd, wb_rd,
        output ex_reg_write, mem_reg_write, wb_reg_write,
        output ex_mem_read, branch_taken, mem_busy,
        input  stage_en, stage_flush, fwd_sel_1, fwd_sel_2, lu_stall
    );

    modport slave (
        input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
        input  ex_rd, mem_rd, wb_rd,
        input  ex_reg_write, mem_reg_write, wb_reg_write,
        input  ex_mem_read, branch_taken, mem_busy,
        output stage_en, stage_flush, fwd_sel_1, fwd_sel_2, lu_stall
    );

endinterface

// File: rtl/pipeline_hazard_ctrl_fwd_select.sv
// Operand forwarding select for one EX source: the younger MEM result wins
// over WB; x0 is never forwarded.
module pipeline_hazard_ctrl_fwd_select
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = 5
) (
    input  logic [REG_ADDR_W-1:0] src,
    input  logic                  uses_src,
    input  logic [REG_ADDR_W-1:0] mem_rd,
    input  logic                  mem_reg_write,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    input  logic                  wb_reg_write,
    output fwd_sel_t              fwd_sel
);

    logic mem_hit;
    logic wb_hit;

    assign mem_hit = uses_src && mem_reg_write && (mem_rd != '0) && (mem_rd == src);
    assign wb_hit  = uses_src && wb_reg_write  && (wb_rd  != '0) && (wb_rd  == src);

    always_comb begin
        fwd_sel = FWD_REG;
        if (mem_hit) begin
            fwd_sel = FWD_MEM;
        end else if (wb_hit) begin
            fwd_sel = FWD_WB;
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush/forwarding controller for the in-order pipeline.
// Optional PIPE_HAZARD_PERF_CNT_EN adds saturating stall/flush event counters.
//
// state    | meaning
// RUN      | normal flow; load-use and branch rules evaluated
// LU_STALL | load-use bubbles still owed, counter holds remaining cycles
// MEM_WAIT | memory busy, whole pipeline frozen; ret_q holds the state to resume
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int NUM_STAGES      = 5,
    parameter int REG_ADDR_W      = 5,
    parameter int LOAD_USE_CYCLES = 1,
    parameter int FLUSH_DEPTH     = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    pipeline_hazard_ctrl_if.slave hz
`ifdef PIPE_HAZARD_PERF_CNT_EN
    ,
    output logic [31:0]           stall_cycles,
    output logic [31:0]           flush_events
`endif
);

    localparam int CNT_W = $clog2(LOAD_USE_CYCLES + 1);

    function automatic logic [NUM_STAGES-1:0] branch_flush_mask();
        logic [NUM_STAGES-1:0] m;
        m = '0;
        for (int i = 1; i < NUM_STAGES; i++) begin
            if (i <= FLUSH_DEPTH) m[i] = 1'b1;
        end
        return m;
    endfunction

    localparam logic [NUM_STAGES-1:0] BRANCH_FLUSH = branch_flush_mask();
    localparam logic [CNT_W-1:0]      CNT_RELOAD   = CNT_W'(LOAD_USE_CYCLES - 1);
    localparam logic [CNT_W-1:0]      CNT_ONE      = CNT_W'(1);

    hazard_state_t         state_q, state_d;
    hazard_state_t         ret_q, ret_d;
    hazard_state_t         eff_state;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  rs1_ex_hit, rs2_ex_hit, load_use;
    logic [NUM_STAGES-1:0] stage_en_c, stage_flush_c;
    logic                  lu_stall_c, branch_apply;
    fwd_sel_t              fwd_1, fwd_2;

    assign rs1_ex_hit = hz.id_uses_rs1 && hz.ex_reg_write && (hz.ex_rd != '0)
                        && (hz.ex_rd == hz.id_rs1);
    assign rs2_ex_hit = hz.id_uses_rs2 && hz.ex_reg_write && (hz.ex_rd != '0)
                        && (hz.ex_rd == hz.id_rs2);
    assign load_use   = hz.ex_mem_read && (rs1_ex_hit || rs2_ex_hit);

    pipeline_hazard_ctrl_fwd_select #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_1 (
        .src           (hz.id_rs1),
        .uses_src      (hz.id_uses_rs1),
        .mem_rd        (hz.mem_rd),
        .mem_reg_write (hz.mem_reg_write),
        .wb_rd         (hz.wb_rd),
        .wb_reg_write  (hz.wb_reg_write),
        .fwd_sel       (fwd_1)
    );

    pipeline_hazard_ctrl_fwd_select #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_2 (
        .src           (hz.id_rs2),
        .uses_src      (hz.id_uses_rs2),
        .mem_rd        (hz.mem_rd),
        .mem_reg_write (hz.mem_reg_write),
        .wb_rd         (hz.wb_rd),
        .wb_reg_write  (hz.wb_reg_write),
        .fwd_sel       (fwd_2)
    );

    // Leaving MEM_WAIT resumes the held state in the same cycle, so all rules
    // below are evaluated against the effective state rather than state_q.
    always_comb begin
        eff_state     = (state_q == MEM_WAIT) ? ret_q : state_q;
        state_d       = eff_state;
        ret_d         = ret_q;
        cnt_d         = cnt_q;
        stage_en_c    = '1;
        stage_flush_c = '0;
        lu_stall_c    = 1'b0;
        branch_apply  = 1'b0;
        if (rst) begin
            stage_en_c    = '0;
            stage_flush_c = '1;
            state_d       = RUN;
            ret_d         = RUN;
            cnt_d         = '0;
        end else if (hz.mem_busy) begin
            stage_en_c = '0;
            state_d    = MEM_WAIT;
            ret_d      = eff_state;
        end else if (hz.branch_taken) begin
            stage_flush_c = BRANCH_FLUSH;
            branch_apply  = 1'b1;
            state_d       = RUN;
        end else if (eff_state == LU_STALL) begin
            stage_en_c[STG_PC]      = 1'b0;
            stage_en_c[STG_IFID]    = 1'b0;
            stage_flush_c[STG_IDEX] = 1'b1;
            lu_stall_c              = 1'b1;
            cnt_d                   = cnt_q - CNT_ONE;
            state_d                 = (cnt_q == CNT_ONE) ? RUN : LU_STALL;
        end else if (load_use) begin
            stage_en_c[STG_PC]      = 1'b0;
            stage_en_c[STG_IFID]    = 1'b0;
            stage_flush_c[STG_IDEX] = 1'b1;
            lu_stall_c              = 1'b1;
            if (LOAD_USE_CYCLES > 1) begin
                cnt_d   = CNT_RELOAD;
                state_d = LU_STALL;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            ret_q   <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ret_q   <= ret_d;
            cnt_q   <= cnt_d;
        end
    end

    assign hz.stage_en    = stage_en_c;
    assign hz.stage_flush = stage_flush_c;
    assign hz.lu_stall    = lu_stall_c;
    assign hz.fwd_sel_1   = rst ? FWD_REG : fwd_1;
    assign hz.fwd_sel_2   = rst ? FWD_REG : fwd_2;

`ifdef PIPE_HAZARD_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= '0;
            flush_events <= '0;
        end else begin
            if ((lu_stall_c || state_q == MEM_WAIT) && stall_cycles != '1) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
            if (branch_apply && flush_events != '1) begin
                flush_events <= flush_events + 32'd1;
            end
        end
    end
`endif

endmodule
